// File: rtl/serial_frame_arbiter.sv
// Round-robin arbiter that owns a shared serial sequence detector: it resets the
// detector, shifts the granted frame in MSB-first and counts detector hits.
module serial_frame_arbiter #(
    parameter int FRAME_W = 8,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               req0,
    input  logic [FRAME_W-1:0] data0,
    input  logic               req1,
    input  logic [FRAME_W-1:0] data1,
    input  logic               det_in,
    output logic               x_out,
    output logic               fsm_rstn,
    output logic               busy,
    output logic [1:0]         grant,
    output logic               done,
    output logic               done_id,
    output logic [CNT_W-1:0]   hit_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int BW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    logic [1:0]         state;
    logic [FRAME_W-1:0] shreg;
    logic [BW-1:0]      bit_cnt;
    logic               last1;
    logic               pick1;

    // On a tie the requester that was not served last wins.
    assign pick1 = req1 & (~req0 | ~last1);

    // NOTE: every register below is assigned with <= so all of them update from
    // the same pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            last1     <= 1'b1;
            x_out     <= 1'b0;
            fsm_rstn  <= 1'b0;
            busy      <= 1'b0;
            grant     <= 2'b00;
            done      <= 1'b0;
            done_id   <= 1'b0;
            hit_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    fsm_rstn <= 1'b0;
                    grant    <= 2'b00;
                    x_out    <= 1'b0;
                    if (req0 | req1) begin
                        state     <= S_LOAD;
                        busy      <= 1'b1;
                        grant     <= pick1 ? 2'b10 : 2'b01;
                        last1     <= pick1;
                        shreg     <= pick1 ? data1 : data0;
                        bit_cnt   <= '0;
                        hit_count <= '0;
                    end
                end
                S_LOAD: begin
                    // Detector has been held in reset for the whole LOAD cycle.
                    state    <= S_SHIFT;
                    fsm_rstn <= 1'b1;
                    x_out    <= shreg[FRAME_W-1];
                    shreg    <= shreg << 1;
                end
                S_SHIFT: begin
                    if (det_in && hit_count != '1) begin
                        hit_count <= hit_count + 1'b1;
                    end
                    if (bit_cnt == BW'(FRAME_W - 1)) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        done_id <= grant[1];
                        x_out   <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        x_out   <= shreg[FRAME_W-1];
                        shreg   <= shreg << 1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    grant    <= 2'b00;
                    fsm_rstn <= 1'b0;
                    x_out    <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule
